// File: rtl/reg_wb_arbiter.sv
// Write-side front end of the integer register file: merges pipeline writeback and
// buffered mul/div results onto the single write port, exports pending-register mask.
module reg_wb_arbiter #(
    parameter int BUF_DEPTH = 2,
    parameter int MAX_DEFER = 4
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        PIPE_WE,
    input  logic [4:0]  PIPE_ADDR,
    input  logic [31:0] PIPE_DATA,
    input  logic        MD_VALID,
    output logic        MD_READY,
    input  logic [4:0]  MD_ADDR,
    input  logic [31:0] MD_DATA,
    output logic        WRITE_ENABLE,
    output logic [4:0]  WRITE_ADDRESS,
    output logic [31:0] WRITE_DATA,
    output logic [31:0] PENDING,
    output logic        PIPE_STALL
);

    localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int CNT_W = $clog2(BUF_DEPTH + 1);
    localparam int DEF_W = $clog2(MAX_DEFER + 1);
    localparam logic [CNT_W-1:0] DEPTH_C    = CNT_W'(BUF_DEPTH);
    localparam logic [DEF_W-1:0] DEFER_LAST = DEF_W'(MAX_DEFER - 1);

    logic [4:0]           buf_addr [BUF_DEPTH];
    logic [31:0]          buf_data [BUF_DEPTH];
    logic [BUF_DEPTH-1:0] buf_vld;
    logic [PTR_W-1:0]     head;
    logic [PTR_W-1:0]     tail;
    logic [CNT_W-1:0]     count;
    logic [DEF_W-1:0]     defer_cnt;

    logic                 pipe_req;
    logic                 fifo_empty;
    logic                 md_live;
    logic [BUF_DEPTH-1:0] kill_mask;
    logic                 head_dead;
    logic                 head_live;
    logic                 issue_head;
    logic                 issue_bypass;
    logic                 do_pop;
    logic                 do_push;

    assign MD_READY = RESET && (count < DEPTH_C);

    always_comb begin
        pipe_req   = PIPE_WE && (PIPE_ADDR != 5'd0);
        fifo_empty = (count == '0);
        md_live    = MD_VALID && MD_READY && (MD_ADDR != 5'd0);
        kill_mask  = '0;
        PENDING    = '0;
        for (int i = 0; i < BUF_DEPTH; i++) begin
            kill_mask[i] = pipe_req && buf_vld[i] && (buf_addr[i] == PIPE_ADDR);
            if (buf_vld[i]) begin
                PENDING[buf_addr[i]] = 1'b1;
            end
        end
        // A killed head leaves this edge without using the write port.
        head_dead    = !fifo_empty && (!buf_vld[head] || kill_mask[head]);
        head_live    = !fifo_empty && !head_dead;
        issue_head   = !pipe_req && head_live;
        issue_bypass = !pipe_req && fifo_empty && md_live;
        do_pop       = issue_head || head_dead;
        do_push      = md_live && !issue_bypass;
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            buf_vld       <= '0;
            head          <= '0;
            tail          <= '0;
            count         <= '0;
            defer_cnt     <= '0;
            WRITE_ENABLE  <= 1'b0;
            WRITE_ADDRESS <= '0;
            WRITE_DATA    <= '0;
            PIPE_STALL    <= 1'b0;
        end else begin
            buf_vld <= buf_vld & ~kill_mask;
            if (do_pop) begin
                buf_vld[head] <= 1'b0;
                head          <= head + PTR_W'(1);
            end
            if (do_push) begin
                buf_vld[tail] <= 1'b1;
                tail          <= tail + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase

            WRITE_ENABLE <= pipe_req || issue_head || issue_bypass;
            if (pipe_req) begin
                WRITE_ADDRESS <= PIPE_ADDR;
                WRITE_DATA    <= PIPE_DATA;
            end else if (issue_head) begin
                WRITE_ADDRESS <= buf_addr[head];
                WRITE_DATA    <= buf_data[head];
            end else if (issue_bypass) begin
                WRITE_ADDRESS <= MD_ADDR;
                WRITE_DATA    <= MD_DATA;
            end

            // Counter saturates so a further loss during the bubble re-raises the stall.
            if (pipe_req && head_live) begin
                if (defer_cnt == DEFER_LAST) begin
                    PIPE_STALL <= 1'b1;
                end else begin
                    PIPE_STALL <= 1'b0;
                    defer_cnt  <= defer_cnt + DEF_W'(1);
                end
            end else begin
                PIPE_STALL <= 1'b0;
                defer_cnt  <= '0;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (do_push) begin
            buf_addr[tail] <= MD_ADDR;
            buf_data[tail] <= MD_DATA;
        end
    end

endmodule

// File: tb/tb_reg_wb_arbiter.sv
// Directed bench for reg_wb_arbiter: queue-based reference model checked every cycle,
// plus literal expectations for each scenario.
module tb_reg_wb_arbiter;

    localparam int BUF_DEPTH = 2;
    localparam int MAX_DEFER = 4;

    logic        CLK = 1'b0;
    logic        RESET = 1'b0;
    logic        PIPE_WE = 1'b0;
    logic [4:0]  PIPE_ADDR = '0;
    logic [31:0] PIPE_DATA = '0;
    logic        MD_VALID = 1'b0;
    logic        MD_READY;
    logic [4:0]  MD_ADDR = '0;
    logic [31:0] MD_DATA = '0;
    logic        WRITE_ENABLE;
    logic [4:0]  WRITE_ADDRESS;
    logic [31:0] WRITE_DATA;
    logic [31:0] PENDING;
    logic        PIPE_STALL;

    reg_wb_arbiter #(.BUF_DEPTH(BUF_DEPTH), .MAX_DEFER(MAX_DEFER)) dut (
        .CLK(CLK), .RESET(RESET),
        .PIPE_WE(PIPE_WE), .PIPE_ADDR(PIPE_ADDR), .PIPE_DATA(PIPE_DATA),
        .MD_VALID(MD_VALID), .MD_READY(MD_READY), .MD_ADDR(MD_ADDR), .MD_DATA(MD_DATA),
        .WRITE_ENABLE(WRITE_ENABLE), .WRITE_ADDRESS(WRITE_ADDRESS), .WRITE_DATA(WRITE_DATA),
        .PENDING(PENDING), .PIPE_STALL(PIPE_STALL)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: buffered results as a queue, kill marks entries dead.
    typedef struct {
        logic [4:0]  a;
        logic [31:0] d;
        bit          alive;
    } ent_t;
    ent_t        m_q[$];
    int          m_defer = 0;
    logic        m_we = 1'b0;
    logic [4:0]  m_wa = '0;
    logic [31:0] m_wd = '0;
    logic        m_stall = 1'b0;

    always @(posedge CLK or negedge RESET) begin
        bit acc, live, preq, was_empty, loss, bypass;
        if (!RESET) begin
            m_q.delete();
            m_defer = 0;
            m_we    = 1'b0;
            m_wa    = '0;
            m_wd    = '0;
            m_stall = 1'b0;
        end else begin
            acc       = MD_VALID && (m_q.size() < BUF_DEPTH);
            live      = acc && (MD_ADDR != 5'd0);
            preq      = PIPE_WE && (PIPE_ADDR != 5'd0);
            was_empty = (m_q.size() == 0);
            loss      = 1'b0;
            bypass    = 1'b0;
            m_we      = 1'b0;
            if (preq) begin
                foreach (m_q[i]) if (m_q[i].a == PIPE_ADDR) m_q[i].alive = 1'b0;
                m_we = 1'b1;
                m_wa = PIPE_ADDR;
                m_wd = PIPE_DATA;
                loss = !was_empty && m_q[0].alive;
            end
            if (!was_empty && !m_q[0].alive) begin
                void'(m_q.pop_front());
            end else if (!preq && !was_empty) begin
                m_we = 1'b1;
                m_wa = m_q[0].a;
                m_wd = m_q[0].d;
                void'(m_q.pop_front());
            end else if (!preq && was_empty && live) begin
                bypass = 1'b1;
                m_we   = 1'b1;
                m_wa   = MD_ADDR;
                m_wd   = MD_DATA;
            end
            if (live && !bypass) m_q.push_back('{MD_ADDR, MD_DATA, 1'b1});
            if (loss) begin
                if (m_defer >= MAX_DEFER - 1) m_stall = 1'b1;
                else begin
                    m_stall = 1'b0;
                    m_defer++;
                end
            end else begin
                m_stall = 1'b0;
                m_defer = 0;
            end
        end
    end

    function automatic logic [31:0] m_pending();
        logic [31:0] p = '0;
        foreach (m_q[i]) if (m_q[i].alive) p[m_q[i].a] = 1'b1;
        return p;
    endfunction

    typedef struct {
        logic [4:0]  a;
        logic [31:0] d;
    } wr_t;
    wr_t wr_log[$];

    always @(negedge CLK) begin
        chk("model_we", {31'd0, WRITE_ENABLE}, {31'd0, m_we});
        chk("model_waddr", {27'd0, WRITE_ADDRESS}, {27'd0, m_wa});
        chk("model_wdata", WRITE_DATA, m_wd);
        chk("model_pending", PENDING, m_pending());
        chk("model_stall", {31'd0, PIPE_STALL}, {31'd0, m_stall});
        chk("model_ready", {31'd0, MD_READY},
            {31'd0, (RESET && (m_q.size() < BUF_DEPTH))});
        if (WRITE_ENABLE === 1'b1) wr_log.push_back('{WRITE_ADDRESS, WRITE_DATA});
    end

    task automatic step(input logic pwe, input logic [4:0] pa, input logic [31:0] pd,
                        input logic mv, input logic [4:0] ma, input logic [31:0] md);
        PIPE_WE   = pwe;
        PIPE_ADDR = pa;
        PIPE_DATA = pd;
        MD_VALID  = mv;
        MD_ADDR   = ma;
        MD_DATA   = md;
        @(posedge CLK);
        @(negedge CLK);
        #1;
    endtask

    task automatic chk_wr(input string name, input logic we, input logic [4:0] a,
                          input logic [31:0] d);
        chk({name, "_we"}, {31'd0, WRITE_ENABLE}, {31'd0, we});
        if (we) begin
            chk({name, "_addr"}, {27'd0, WRITE_ADDRESS}, {27'd0, a});
            chk({name, "_data"}, WRITE_DATA, d);
        end
    endtask

    initial begin
        int n;
        repeat (2) @(negedge CLK);
        #1;
        chk("rst_we", {31'd0, WRITE_ENABLE}, 32'd0);
        chk("rst_pending", PENDING, 32'd0);
        chk("rst_ready", {31'd0, MD_READY}, 32'd0);
        chk("rst_stall", {31'd0, PIPE_STALL}, 32'd0);
        RESET = 1'b1;
        #1;
        chk("rel_ready", {31'd0, MD_READY}, 32'd1);

        // Bypass straight to the write port.
        step(0, 0, 0, 1, 5, 32'h1234);
        chk_wr("bypass", 1, 5, 32'h1234);
        chk("bypass_pending", PENDING, 32'd0);

        // Pipeline starves two buffered results until a stall bubble.
        step(1, 3, 32'h300, 1, 7, 32'hAA);
        chk_wr("defer_p0", 1, 3, 32'h300);
        chk("defer_pend1", PENDING, 32'h80);
        step(1, 3, 32'h301, 1, 8, 32'hBB);
        chk("defer_pend2", PENDING, 32'h180);
        chk("defer_full_ready", {31'd0, MD_READY}, 32'd0);
        step(1, 3, 32'h302, 0, 0, 0);
        step(1, 3, 32'h303, 0, 0, 0);
        chk("defer_nostall", {31'd0, PIPE_STALL}, 32'd0);
        step(1, 3, 32'h304, 0, 0, 0);
        chk("defer_stall", {31'd0, PIPE_STALL}, 32'd1);
        step(0, 0, 0, 0, 0, 0);
        chk_wr("defer_x7", 1, 7, 32'hAA);
        chk("defer_stall_drop", {31'd0, PIPE_STALL}, 32'd0);
        chk("defer_pend3", PENDING, 32'h100);
        step(1, 3, 32'h305, 0, 0, 0);
        chk_wr("defer_p5", 1, 3, 32'h305);
        step(0, 0, 0, 0, 0, 0);
        chk_wr("defer_x8", 1, 8, 32'hBB);
        chk("defer_pend4", PENDING, 32'd0);

        // WAW kill of a buffered result.
        step(1, 4, 32'h44, 1, 9, 32'h55);
        chk("kill_pend", PENDING, 32'h200);
        n = wr_log.size();
        step(1, 9, 32'h66, 0, 0, 0);
        chk_wr("kill_pipe", 1, 9, 32'h66);
        chk("kill_pend_clr", PENDING, 32'd0);
        repeat (3) step(0, 0, 0, 0, 0, 0);
        chk("kill_no_write", wr_log.size(), n + 1);

        // x0 from both sources.
        chk("x0_ready_pre", {31'd0, MD_READY}, 32'd1);
        step(1, 0, 32'hDEAD, 1, 0, 32'hBEEF);
        chk("x0_we", {31'd0, WRITE_ENABLE}, 32'd0);
        chk("x0_ready_post", {31'd0, MD_READY}, 32'd1);
        chk("x0_pending", PENDING, 32'd0);

        // Full FIFO back-pressure and ordering.
        step(1, 3, 32'h310, 1, 10, 32'hA0);
        step(1, 3, 32'h311, 1, 11, 32'hB0);
        chk("full_ready", {31'd0, MD_READY}, 32'd0);
        chk("full_pend", PENDING, 32'hC00);
        n = wr_log.size();
        step(0, 0, 0, 1, 12, 32'hC0);
        chk_wr("full_x10", 1, 10, 32'hA0);
        chk("full_ready2", {31'd0, MD_READY}, 32'd1);
        step(0, 0, 0, 1, 12, 32'hC0);
        chk_wr("full_x11", 1, 11, 32'hB0);
        chk("full_pend2", PENDING, 32'h1000);
        step(0, 0, 0, 0, 0, 0);
        chk_wr("full_x12", 1, 12, 32'hC0);
        chk("order_len", wr_log.size(), n + 3);
        if (wr_log.size() == n + 3) begin
            chk("order0", {27'd0, wr_log[n].a}, 32'd10);
            chk("order1", {27'd0, wr_log[n+1].a}, 32'd11);
            chk("order2", {27'd0, wr_log[n+2].a}, 32'd12);
        end

        // Asynchronous reset with two buffered entries.
        step(1, 3, 32'h320, 1, 13, 32'hD0);
        step(1, 3, 32'h321, 1, 14, 32'hE0);
        chk("arst_pre_pend", PENDING, 32'h6000);
        PIPE_WE  = 1'b0;
        MD_VALID = 1'b0;
        #2 RESET = 1'b0;
        #1;
        chk("arst_we", {31'd0, WRITE_ENABLE}, 32'd0);
        chk("arst_pending", PENDING, 32'd0);
        chk("arst_stall", {31'd0, PIPE_STALL}, 32'd0);
        chk("arst_ready", {31'd0, MD_READY}, 32'd0);
        @(negedge CLK);
        #1 RESET = 1'b1;
        n = wr_log.size();
        repeat (4) step(0, 0, 0, 0, 0, 0);
        chk("arst_no_write", wr_log.size(), n);
        chk("arst_ready_rel", {31'd0, MD_READY}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
